// File: rtl/addrgen_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | addrgen_seq_ctrl_if                                                  |
// | Shared types and the command / address-generator bundle for the      |
// | tile sequencer.                                                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+

package params;
    typedef enum logic [1:0] {
        FP32 = 2'd0,
        FP16 = 2'd1,
        INT8 = 2'd2,
        INT4 = 2'd3
    } datatype;

    typedef struct packed {
        datatype    dt;
        logic [1:0] rc;
    } addrgen_t;
endpackage

interface addrgen_seq_ctrl_if;
    import params::*;

    logic       start;
    datatype    cfg_datatype;
    logic [1:0] cfg_rc;
    logic [7:0] cfg_tiles;
    logic       stall;
    logic       ag_rst;
    logic       ag_en;
    logic       ag_cmin;
    addrgen_t   ag_addrs;
    logic       busy;
    logic [7:0] tile_idx;
    logic       done;
    logic       err;

    modport master (
        output start, cfg_datatype, cfg_rc, cfg_tiles, stall,
        input  ag_rst, ag_en, ag_cmin, ag_addrs, busy, tile_idx, done, err
    );

    modport slave (
        input  start, cfg_datatype, cfg_rc, cfg_tiles, stall,
        output ag_rst, ag_en, ag_cmin, ag_addrs, busy, tile_idx, done, err
    );
endinterface
`default_nettype wire

// File: rtl/addrgen_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | addrgen_seq_ctrl                                                     |
// | Per-tile clear / load / compute sequencer for the edge address       |
// | generator of the systolic array.                                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+

module addrgen_seq_ctrl
    import params::*;
#(
    parameter int LD_FP32   = 64,
    parameter int LD_FP16   = 64,
    parameter int LD_INT8   = 4,
    parameter int LD_INT4   = 8,
    parameter int CM_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    addrgen_seq_ctrl_if.slave bus
);

    localparam int         c_CNT_W        = (CM_CYCLES > 1) ? $clog2(CM_CYCLES) : 1;
    localparam logic [6:0] c_LD_FP32_LAST = 7'(LD_FP32 - 1);
    localparam logic [6:0] c_LD_FP16_LAST = 7'(LD_FP16 - 1);
    localparam logic [6:0] c_LD_INT8_LAST = 7'(LD_INT8 - 1);
    localparam logic [6:0] c_LD_INT4_LAST = 7'(LD_INT4 - 1);
    localparam logic [c_CNT_W-1:0] c_CM_LAST = c_CNT_W'(CM_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_LOAD = 3'd2,
        S_COMP = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [6:0]         r_beat;
    logic [c_CNT_W-1:0] r_cyc;
    logic [7:0]         r_tiles;
    logic [7:0]         r_tile_idx;
    addrgen_t           r_addrs;
    logic               r_ag_rst;
    logic               r_ld_phase;
    logic               r_ag_cmin;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic [6:0]         w_ld_last;
    logic               w_rc_bad;
    logic               w_comp_end;
    logic               w_last_tile;

    assign w_rc_bad    = (bus.cfg_rc == 2'b11);
    assign w_comp_end  = (r_cyc == c_CM_LAST);
    assign w_last_tile = (r_tile_idx == (r_tiles - 8'd1));

    always_comb begin
        w_ld_last = c_LD_FP32_LAST;
        case (r_addrs.dt)
            FP16:    w_ld_last = c_LD_FP16_LAST;
            INT8:    w_ld_last = c_LD_INT8_LAST;
            INT4:    w_ld_last = c_LD_INT4_LAST;
            default: w_ld_last = c_LD_FP32_LAST;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !w_rc_bad) begin
                    w_state_nxt = (bus.cfg_tiles == 8'd0) ? S_FIN : S_CLR;
                end
            end
            S_CLR:  w_state_nxt = S_LOAD;
            S_LOAD: begin
                // A stalled final beat holds the phase until it is retried.
                if (!bus.stall && (r_beat == w_ld_last)) begin
                    w_state_nxt = S_COMP;
                end
            end
            S_COMP: begin
                if (w_comp_end) begin
                    w_state_nxt = w_last_tile ? S_FIN : S_CLR;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_beat     <= '0;
            r_cyc      <= '0;
            r_tiles    <= '0;
            r_tile_idx <= '0;
            r_addrs    <= '0;
            r_ag_rst   <= 1'b0;
            r_ld_phase <= 1'b0;
            r_ag_cmin  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            // Phase outputs are registered from the next state so they align with it.
            r_ag_rst   <= (w_state_nxt == S_CLR);
            r_ld_phase <= (w_state_nxt == S_LOAD);
            r_ag_cmin  <= (w_state_nxt == S_COMP);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_FIN);
            r_err      <= (r_state == S_IDLE) && bus.start && w_rc_bad;

            case (r_state)
                S_IDLE: begin
                    if (bus.start && !w_rc_bad && (bus.cfg_tiles != 8'd0)) begin
                        r_addrs.dt <= bus.cfg_datatype;
                        r_addrs.rc <= bus.cfg_rc;
                        r_tiles    <= bus.cfg_tiles;
                        r_tile_idx <= 8'd0;
                    end
                end
                S_CLR: begin
                    r_beat <= '0;
                    r_cyc  <= '0;
                end
                S_LOAD: begin
                    if (!bus.stall) begin
                        r_beat <= r_beat + 7'd1;
                    end
                end
                S_COMP: begin
                    r_cyc <= r_cyc + 1'b1;
                    if (w_comp_end && !w_last_tile) begin
                        r_tile_idx <= r_tile_idx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ag_rst   = r_ag_rst;
    assign bus.ag_en    = r_ld_phase & ~bus.stall;
    assign bus.ag_cmin  = r_ag_cmin;
    assign bus.ag_addrs = r_addrs;
    assign bus.busy     = r_busy;
    assign bus.tile_idx = r_tile_idx;
    assign bus.done     = r_done;
    assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_addrgen_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_addrgen_seq_ctrl                                                  |
// | Cycle-by-cycle check of the tile sequencer against a phase model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+

module tb_addrgen_seq_ctrl;
    import params::*;

    localparam int c_LD_FP32 = 64;
    localparam int c_LD_FP16 = 64;
    localparam int c_LD_INT8 = 4;
    localparam int c_LD_INT4 = 8;
    localparam int c_CM      = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    addrgen_t   exp_addrs;
    logic [7:0] exp_idx;

    addrgen_seq_ctrl_if bus();

    addrgen_seq_ctrl #(
        .LD_FP32   (c_LD_FP32),
        .LD_FP16   (c_LD_FP16),
        .LD_INT8   (c_LD_INT8),
        .LD_INT4   (c_LD_INT4),
        .CM_CYCLES (c_CM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int ld_of(input datatype d);
        case (d)
            FP32:    return c_LD_FP32;
            FP16:    return c_LD_FP16;
            INT8:    return c_LD_INT8;
            default: return c_LD_INT4;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string ph, input logic e_rst, input logic e_en,
                           input logic e_cmin, input logic e_busy, input logic e_done,
                           input logic e_err);
        chk({ph, ".ag_rst"},   32'(bus.ag_rst),   32'(e_rst));
        chk({ph, ".ag_en"},    32'(bus.ag_en),    32'(e_en));
        chk({ph, ".ag_cmin"},  32'(bus.ag_cmin),  32'(e_cmin));
        chk({ph, ".busy"},     32'(bus.busy),     32'(e_busy));
        chk({ph, ".done"},     32'(bus.done),     32'(e_done));
        chk({ph, ".err"},      32'(bus.err),      32'(e_err));
        chk({ph, ".tile_idx"}, 32'(bus.tile_idx), 32'(exp_idx));
        chk({ph, ".ag_addrs"}, 32'(bus.ag_addrs), 32'(exp_addrs));
    endtask

    task automatic scramble(input bit noise);
        if (noise) begin
            bus.start        = 1'($urandom_range(0, 1));
            bus.cfg_datatype = datatype'($urandom_range(0, 3));
            bus.cfg_rc       = 2'($urandom_range(0, 3));
            bus.cfg_tiles    = 8'($urandom_range(0, 255));
        end else begin
            bus.start = 1'b0;
        end
    endtask

    // stall_mode: 0 none, 1 random, 2 one burst of 5 cycles after beat 20
    task automatic run_cmd(input datatype dt, input logic [1:0] rc, input logic [7:0] tiles,
                           input int stall_mode, input bit noise, input int abort_tile);
        int remaining;
        int beats;
        int burst;
        int iter;
        bus.start        = 1'b1;
        bus.cfg_datatype = dt;
        bus.cfg_rc       = rc;
        bus.cfg_tiles    = tiles;
        bus.stall        = 1'($urandom_range(0, 1));
        #1;
        chk_out("idle_start", 0, 0, 0, 0, 0, 0);
        tick();
        scramble(noise);

        if (rc == 2'b11) begin
            #1;
            chk_out("reject", 0, 0, 0, 0, 0, 1);
            tick();
            bus.start = 1'b0;
            #1;
            chk_out("post_reject", 0, 0, 0, 0, 0, 0);
            return;
        end
        if (tiles == 8'd0) begin
            #1;
            chk_out("zero_fin", 0, 0, 0, 1, 1, 0);
            tick();
            bus.start = 1'b0;
            #1;
            chk_out("zero_idle", 0, 0, 0, 0, 0, 0);
            return;
        end

        exp_addrs.dt = dt;
        exp_addrs.rc = rc;
        for (int t = 0; t < int'(tiles); t++) begin
            exp_idx   = 8'(t);
            bus.stall = 1'($urandom_range(0, 1));
            #1;
            chk_out("clr", 1, 0, 0, 1, 0, 0);
            tick();

            remaining = ld_of(dt);
            beats     = 0;
            burst     = 0;
            iter      = 0;
            while (remaining > 0) begin
                scramble(noise);
                case (stall_mode)
                    1:       bus.stall = ($urandom_range(0, 3) == 0);
                    2:       bus.stall = (beats == 20) && (burst < 5);
                    default: bus.stall = 1'b0;
                endcase
                if (iter > 400) bus.stall = 1'b0;
                #1;
                chk_out("load", 0, !bus.stall, 0, 1, 0, 0);
                if (bus.stall) burst++;
                else begin
                    remaining--;
                    beats++;
                end
                iter++;
                tick();
            end

            for (int c = 0; c < c_CM; c++) begin
                scramble(noise);
                bus.stall = 1'($urandom_range(0, 1));
                #1;
                chk_out("comp", 0, 0, 1, 1, 0, 0);
                if ((t == abort_tile) && (c == 3)) begin
                    bus.start = 1'b0;
                    rst       = 1'b1;
                    tick();
                    rst       = 1'b0;
                    exp_addrs = '0;
                    exp_idx   = 8'd0;
                    #1;
                    chk_out("abort_reset", 0, 0, 0, 0, 0, 0);
                    tick();
                    #1;
                    chk_out("abort_idle", 0, 0, 0, 0, 0, 0);
                    return;
                end
                tick();
            end
        end

        scramble(noise);
        #1;
        chk_out("fin", 0, 0, 0, 1, 1, 0);
        tick();
        bus.start = 1'b0;
        bus.stall = 1'($urandom_range(0, 1));
        #1;
        chk_out("idle_after", 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.cfg_datatype = FP32;
        bus.cfg_rc       = 2'b00;
        bus.cfg_tiles    = 8'd0;
        bus.stall        = 1'b0;
        exp_addrs        = '0;
        exp_idx          = 8'd0;
        tick();
        tick();
        #1;
        chk_out("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        run_cmd(FP32, 2'b00, 8'd1, 0, 1'b0, -1);
        run_cmd(INT8, 2'b10, 8'd3, 0, 1'b0, -1);
        run_cmd(FP16, 2'b01, 8'd1, 2, 1'b0, -1);
        run_cmd(INT8, 2'b11, 8'd2, 0, 1'b0, -1);
        run_cmd(FP32, 2'b00, 8'd0, 0, 1'b0, -1);
        run_cmd(INT4, 2'b01, 8'd2, 0, 1'b0, 1);
        run_cmd(INT4, 2'b10, 8'd2, 1, 1'b0, -1);
        run_cmd(FP32, 2'b10, 8'd1, 1, 1'b1, -1);

        for (int i = 0; i < 12; i++) begin
            run_cmd(datatype'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    8'($urandom_range(0, 4)), int'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
